lsu_mem_arbiter: RTL and testbench
==================================

# lsu_mem_arbiter

Shares the single data-memory port between the load/store unit (requester 0) and the page-table walker (requester 1). Runs one transaction at a time through a three-state sequencer, with round-robin priority and a lock that keeps the port with one owner across AMO read-modify-write pairs. Sits between the LSU/PTW and the data-cache/memory interface. Handles pipeline flush for LSU-owned transactions.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low; clock i_clk
- i_flush  in  1  pipeline flush; affects requester 0 only
- i_rN_req  in  1  requester N (N=0,1) request valid; held with fields until o_rN_ack
- i_rN_addr  in  ADDR_W  request address
- i_rN_wdata  in  DATA_W  store data
- i_rN_we  in  1  1=write, 0=read
- i_rN_size  in  2  log2 bytes (0..3)
- i_rN_lock  in  1  keep ownership after this transaction completes
- o_rN_ack  out  1  one-cycle pulse: request latched; requester drops i_rN_req next cycle
- o_rN_rvalid  out  1  one-cycle pulse: transaction complete
- o_rN_rdata  out  DATA_W  read data, valid with o_rN_rvalid
- o_mem_req  out  1  memory request valid
- o_mem_addr / o_mem_wdata / o_mem_we / o_mem_size  out  ADDR_W / DATA_W / 1 / 2  latched request fields
- i_mem_ack  in  1  memory accepted the request this cycle
- i_mem_rvalid  in  1  completion; exactly one per accepted request, arrives no earlier than the cycle after i_mem_ack
- i_mem_rdata  in  DATA_W  read data (don't-care for writes)

## Operation
- States: IDLE, REQ, WAIT. Registers: owner (1b), last (1b), locked (1b), drain (1b), plus latched request fields.
- IDLE arbitration:
  - Eligible set: {owner} if locked, else every requester with req high. r0 is excluded in a flush cycle.
  - Both eligible: the requester not equal to last wins.
  - On a win: latch fields, set owner and last, set locked to the winner's lock bit, pulse o_rN_ack next cycle, go to REQ.
- REQ: o_mem_req=1 with latched fields. On i_mem_ack go to WAIT.
- WAIT: on i_mem_rvalid go to IDLE.
  - If drain=0: pulse o_owner_rvalid next cycle with o_rdata=i_mem_rdata.
  - If drain=1: discard the completion and clear drain.
- Lock: locked stays set until an owner transaction with lock=0 completes. While locked, the other requester waits indefinitely.
- Flush (i_flush=1):
  - REQ, owner 0, i_mem_ack=0: drop the request; go to IDLE with no rvalid. If i_mem_ack=1 in the same cycle, the memory has accepted, so go to WAIT with drain=1.
  - WAIT, owner 0: set drain=1.
  - Any state: if owner is 0, clear locked.
  - Owner 1 transactions are unaffected.
- o_rN_rdata holds its value between pulses.

## Timing
- Reset values: all outputs 0, state IDLE, last=1 (r0 wins first tie), owner=0, locked=0, drain=0.
- Reset has priority over flush and aborts any transaction mid-flight. Any later i_mem_rvalid in IDLE is ignored.
- Registered outputs:
  - Request in IDLE at cycle t gives o_mem_req and o_rN_ack at t+1.
  - i_mem_ack at t+1 puts the arbiter in WAIT at t+2.
  - i_mem_rvalid at t+2 gives o_rN_rvalid at t+3, with IDLE at t+3.
  - Minimum 3-cycle latency. Next o_mem_req no earlier than t+4.
- o_mem_req and its fields stay stable while i_mem_ack=0 (unbounded wait).
- A simultaneous request from the second requester during REQ/WAIT is held and arbitrated in the next IDLE.
- i_mem_rvalid outside WAIT is ignored.

## Test plan
- Single read, r0 addr 0x1000, mem ack same cycle, rvalid next cycle with 0xDEAD → o_r0_ack at t+1, o_mem_addr=0x1000, o_r0_rvalid at t+3 with rdata 0xDEAD; r1 outputs stay 0.
- Both requesters held high continuously after reset → grants alternate r0, r1, r0, r1; each transaction runs IDLE→REQ→WAIT.
- r0 AMO: read with lock=1, then write with lock=0, r1 requesting throughout → r1 is not granted until the r0 write's rvalid; r1's ack is then 1 cycle after the r0 write's rvalid.
- Flush during r0 WAIT with a read outstanding, rvalid 2 cycles later with 0x55 → no o_r0_rvalid; state IDLE; the next r1 request is granted normally.
- Flush in REQ with owner 0 and i_mem_ack=0 → o_mem_req drops next cycle with no rvalid. Repeat with i_mem_ack=1 in the flush cycle → drain set, the completion is absorbed, no o_r0_rvalid.
- Reset asserted in WAIT → all outputs 0 next cycle; a stray i_mem_rvalid is ignored; the first tie after reset goes to r0.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the single data-memory port between the load/store unit (requester 0)
// and the page-table walker (requester 1). It runs one transaction at a time through an
// IDLE -> REQ -> WAIT sequencer. Priority is round-robin. A lock holds the port for one owner
// across AMO read-modify-write pairs, and flush handling covers LSU-owned transactions.
//
// Ports:
//   i_clk, i_rst_n     clock; synchronous active-low reset
//   i_flush            pipeline flush (requester 0 only)
//   i_rN_*             requester N request: req/addr/wdata/we/size/lock
//   o_rN_ack           one-cycle pulse: request latched
//   o_rN_rvalid/rdata  one-cycle completion pulse; rdata holds between pulses
//   o_mem_*            memory request and latched fields
//   i_mem_ack          memory accepted the request
//   i_mem_rvalid/rdata memory completion and read data
module lsu_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_r0_req,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  input  logic              i_r0_we,
  input  logic [1:0]        i_r0_size,
  input  logic              i_r0_lock,
  output logic              o_r0_ack,
  output logic              o_r0_rvalid,
  output logic [DATA_W-1:0] o_r0_rdata,
  input  logic              i_r1_req,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  input  logic              i_r1_we,
  input  logic [1:0]        i_r1_size,
  input  logic              i_r1_lock,
  output logic              o_r1_ack,
  output logic              o_r1_rvalid,
  output logic [DATA_W-1:0] o_r1_rdata,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_size,
  input  logic              i_mem_ack,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              locked_q, locked_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic flush_own0;
  logic lock_eff;
  logic elig0, elig1, win;

  // A flush only touches transactions owned by the LSU.
  assign flush_own0 = i_flush && !owner_q;
  // Flush releases an LSU lock immediately, so the walker may compete in the same cycle.
  assign lock_eff   = locked_q && !flush_own0;
  assign elig0      = i_r0_req && !i_flush && (!lock_eff || !owner_q);
  assign elig1      = i_r1_req && (!lock_eff || owner_q);
  // On a tie the requester that did not win last time goes first.
  assign win        = (elig0 && elig1) ? !last_q : elig1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    locked_d = locked_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    size_d   = size_q;
    ack_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    if (flush_own0) locked_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          owner_d = win;
          last_d  = win;
          state_d = StReq;
          if (win) begin
            addr_d   = i_r1_addr;
            wdata_d  = i_r1_wdata;
            we_d     = i_r1_we;
            size_d   = i_r1_size;
            locked_d = i_r1_lock;
            ack_d    = 2'b10;
          end else begin
            addr_d   = i_r0_addr;
            wdata_d  = i_r0_wdata;
            we_d     = i_r0_we;
            size_d   = i_r0_size;
            locked_d = i_r0_lock;
            ack_d    = 2'b01;
          end
        end
      end
      StReq: begin
        if (i_mem_ack) begin
          state_d = StWait;
          // Memory already accepted; its completion must be absorbed.
          if (flush_own0) drain_d = 1'b1;
        end else if (flush_own0) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (i_mem_rvalid) begin
          state_d = StIdle;
          drain_d = 1'b0;
          if (!drain_q && !flush_own0) begin
            if (owner_q) begin
              rvalid_d = 2'b10;
              rdata1_d = i_mem_rdata;
            end else begin
              rvalid_d = 2'b01;
              rdata0_d = i_mem_rdata;
            end
          end
        end else if (flush_own0) begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      locked_q <= 1'b0;
      drain_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      ack_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      size_q   <= size_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign o_r0_ack    = ack_q[0];
  assign o_r1_ack    = ack_q[1];
  assign o_r0_rvalid = rvalid_q[0];
  assign o_r1_rvalid = rvalid_q[1];
  assign o_r0_rdata  = rdata0_q;
  assign o_r1_rdata  = rdata1_q;
  assign o_mem_req   = (state_q == StReq);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = we_q;
  assign o_mem_size  = size_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter. Inputs change 1 ns after the rising edge, and outputs are
// sampled at the same point, so each tick() observes the registers loaded at that edge.
module tb_lsu_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_r0_req, i_r0_we, i_r0_lock;
  logic [63:0] i_r0_addr, i_r0_wdata;
  logic [1:0]  i_r0_size;
  logic        o_r0_ack, o_r0_rvalid;
  logic [63:0] o_r0_rdata;
  logic        i_r1_req, i_r1_we, i_r1_lock;
  logic [63:0] i_r1_addr, i_r1_wdata;
  logic [1:0]  i_r1_size;
  logic        o_r1_ack, o_r1_rvalid;
  logic [63:0] o_r1_rdata;
  logic        o_mem_req, o_mem_we;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [1:0]  o_mem_size;
  logic        i_mem_ack, i_mem_rvalid;
  logic [63:0] i_mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_r0_req    (i_r0_req),
    .i_r0_addr   (i_r0_addr),
    .i_r0_wdata  (i_r0_wdata),
    .i_r0_we     (i_r0_we),
    .i_r0_size   (i_r0_size),
    .i_r0_lock   (i_r0_lock),
    .o_r0_ack    (o_r0_ack),
    .o_r0_rvalid (o_r0_rvalid),
    .o_r0_rdata  (o_r0_rdata),
    .i_r1_req    (i_r1_req),
    .i_r1_addr   (i_r1_addr),
    .i_r1_wdata  (i_r1_wdata),
    .i_r1_we     (i_r1_we),
    .i_r1_size   (i_r1_size),
    .i_r1_lock   (i_r1_lock),
    .o_r1_ack    (o_r1_ack),
    .o_r1_rvalid (o_r1_rvalid),
    .o_r1_rdata  (o_r1_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_size  (o_mem_size),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  // Memory handshake after a grant: ack at t+1, rvalid at t+2, check the completion at t+3.
  task automatic finish(input int who, input logic [63:0] rd);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rd;
    check_eq("wait_no_req", {63'd0, o_mem_req}, 64'd0);
    tick();
    i_mem_rvalid = 1'b0;
    check_eq($sformatf("rvalid_r%0d", who), {63'd0, (who == 0) ? o_r0_rvalid : o_r1_rvalid},
             64'd1);
    check_eq($sformatf("rvalid_other_r%0d", who),
             {63'd0, (who == 0) ? o_r1_rvalid : o_r0_rvalid}, 64'd0);
    check_eq($sformatf("rdata_r%0d", who), (who == 0) ? o_r0_rdata : o_r1_rdata, rd);
  endtask

  // Advance from an IDLE cycle with requests presented, expect a grant to 'who' at addr.
  task automatic serve(input int who, input logic [63:0] addr, input logic [63:0] rd);
    tick();
    check_eq($sformatf("ack_r%0d", who), {62'd0, o_r1_ack, o_r0_ack}, (who == 0) ? 64'd1 : 64'd2);
    check_eq("mem_req", {63'd0, o_mem_req}, 64'd1);
    check_eq("mem_addr", o_mem_addr, addr);
    finish(who, rd);
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0;
    i_r0_req = 1'b0; i_r0_we = 1'b0; i_r0_lock = 1'b0; i_r0_addr = '0; i_r0_wdata = '0;
    i_r0_size = 2'd3;
    i_r1_req = 1'b0; i_r1_we = 1'b0; i_r1_lock = 1'b0; i_r1_addr = '0; i_r1_wdata = '0;
    i_r1_size = 2'd3;
    i_mem_ack = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Reset state.
    do_reset();
    check_eq("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
    check_eq("rst_acks", {62'd0, o_r1_ack, o_r0_ack}, 64'd0);
    check_eq("rst_rvalids", {62'd0, o_r1_rvalid, o_r0_rvalid}, 64'd0);
    check_eq("rst_addr", o_mem_addr, 64'd0);

    // Single r0 read of 0x1000 returning 0xDEAD.
    i_r0_req = 1'b1; i_r0_addr = 64'h1000;
    tick();
    i_r0_req = 1'b0;
    check_eq("t1_ack", {62'd0, o_r1_ack, o_r0_ack}, 64'd1);
    check_eq("t1_addr", o_mem_addr, 64'h1000);
    check_eq("t1_we", {63'd0, o_mem_we}, 64'd0);
    finish(0, 64'hDEAD);
    check_eq("t1_r1_rdata", o_r1_rdata, 64'd0);
    tick();
    check_eq("t1_rvalid_pulse", {63'd0, o_r0_rvalid}, 64'd0);
    check_eq("t1_rdata_hold", o_r0_rdata, 64'hDEAD);

    // Both held high after reset: grants alternate starting with r0.
    do_reset();
    i_r0_req = 1'b1; i_r0_addr = 64'hA0;
    i_r1_req = 1'b1; i_r1_addr = 64'hB0;
    serve(0, 64'hA0, 64'h10);
    serve(1, 64'hB0, 64'h11);
    serve(0, 64'hA0, 64'h12);
    serve(1, 64'hB0, 64'h13);

    // AMO pair on r0 with r1 requesting throughout; r1 waits until the write completes.
    i_r0_lock = 1'b1; i_r0_addr = 64'hC0;
    serve(0, 64'hC0, 64'h21);
    i_r0_lock = 1'b0; i_r0_we = 1'b1; i_r0_wdata = 64'h5A;
    tick();
    check_eq("amo_wr_ack", {62'd0, o_r1_ack, o_r0_ack}, 64'd1);
    check_eq("amo_wr_we", {63'd0, o_mem_we}, 64'd1);
    check_eq("amo_wr_wdata", o_mem_wdata, 64'h5A);
    finish(0, 64'h0);
    i_r0_req = 1'b0; i_r0_we = 1'b0;
    tick();
    check_eq("amo_r1_ack", {62'd0, o_r1_ack, o_r0_ack}, 64'd2);
    i_r1_req = 1'b0;
    finish(1, 64'h31);

    // Flush during r0 WAIT; the late completion is absorbed.
    do_reset();
    i_r0_req = 1'b1; i_r0_addr = 64'hD0;
    tick();
    i_r0_req = 1'b0; i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h55;
    tick();
    i_mem_rvalid = 1'b0;
    check_eq("fw_no_rvalid", {63'd0, o_r0_rvalid}, 64'd0);
    check_eq("fw_rdata", o_r0_rdata, 64'd0);
    i_r1_req = 1'b1; i_r1_addr = 64'hE0;
    tick();
    i_r1_req = 1'b0;
    check_eq("fw_r1_ack", {62'd0, o_r1_ack, o_r0_ack}, 64'd2);
    finish(1, 64'h66);

    // Flush in REQ without ack, after a couple of stalled cycles.
    i_r0_req = 1'b1; i_r0_addr = 64'hF0; i_r0_size = 2'd1;
    tick();
    i_r0_req = 1'b0;
    tick();
    tick();
    check_eq("stall_req", {63'd0, o_mem_req}, 64'd1);
    check_eq("stall_addr", o_mem_addr, 64'hF0);
    check_eq("stall_size", {62'd0, o_mem_size}, 64'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check_eq("fr_req_drop", {63'd0, o_mem_req}, 64'd0);
    tick();
    check_eq("fr_no_rvalid", {63'd0, o_r0_rvalid}, 64'd0);
    check_eq("fr_idle", {63'd0, o_mem_req}, 64'd0);

    // Flush in REQ coinciding with i_mem_ack: drain then recover.
    i_r0_req = 1'b1; i_r0_addr = 64'h100; i_r0_size = 2'd3;
    tick();
    i_r0_req = 1'b0; i_flush = 1'b1; i_mem_ack = 1'b1;
    tick();
    i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 64'h99;
    check_eq("fa_req_low", {63'd0, o_mem_req}, 64'd0);
    tick();
    i_mem_rvalid = 1'b0;
    check_eq("fa_no_rvalid", {63'd0, o_r0_rvalid}, 64'd0);
    check_eq("fa_rdata", o_r0_rdata, 64'd0);
    i_r0_req = 1'b1; i_r0_addr = 64'h108;
    tick();
    i_r0_req = 1'b0;
    check_eq("fa_next_ack", {62'd0, o_r1_ack, o_r0_ack}, 64'd1);
    finish(0, 64'h77);

    // Reset in WAIT, stray completion, then first tie goes to r0.
    i_r1_req = 1'b1; i_r1_addr = 64'h200;
    tick();
    i_r1_req = 1'b0; i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_eq("rw_mem_req", {63'd0, o_mem_req}, 64'd0);
    check_eq("rw_acks", {62'd0, o_r1_ack, o_r0_ack}, 64'd0);
    check_eq("rw_rdata0", o_r0_rdata, 64'd0);
    check_eq("rw_rdata1", o_r1_rdata, 64'd0);
    check_eq("rw_addr", o_mem_addr, 64'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hBAD;
    tick();
    i_mem_rvalid = 1'b0;
    check_eq("rw_stray", {62'd0, o_r1_rvalid, o_r0_rvalid}, 64'd0);
    check_eq("rw_stray_req", {63'd0, o_mem_req}, 64'd0);
    i_r0_req = 1'b1; i_r0_addr = 64'h300;
    i_r1_req = 1'b1; i_r1_addr = 64'h400;
    serve(0, 64'h300, 64'h88);
    i_r0_req = 1'b0; i_r1_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
